adc_serial_reader: RTL and testbench
====================================

Name: adc_serial_reader

Overview:
- Parametrised multi-channel successor to the single-line serial ADC capture in `top`.
- Drives CONV_ST and S_CLK to one or more simultaneous-sampling serial ADCs.
- Shifts in DATA_WIDTH bits per channel, MSB first, from NUM_CH parallel S_DATA lines.
- Presents each completed sample set through a valid/ready output register.
- Supports single-shot (trigger) and continuous (fixed sample period) modes.

Parameters:
- DATA_WIDTH, 12: bits per channel per conversion (2..32).
- NUM_CH, 2: number of parallel S_DATA lines sharing S_CLK/CONV_ST (1..8).
- CLK_DIV, 4: S_CLK half-period in fpga_clk cycles (>=1).
- CONV_PULSE, 2: CONV_ST high time in fpga_clk cycles (>=1).
- CONV_WAIT, 20: cycles from CONV_ST falling to the first S_CLK rise (>=1).
- SAMPLE_PERIOD, 1000: continuous-mode start-to-start spacing in fpga_clk cycles.

Ports:
- fpga_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; conversions are allowed only while high (driven from start_switch).
- cont_mode  in  1  1 = continuous, 0 = single-shot.
- trig  in  1  single-cycle pulse; starts one conversion in single-shot mode.
- S_DATA  in  NUM_CH  serial data lines, bit c belongs to channel c.
- S_CLK  out  1  serial clock, idles low.
- CONV_ST  out  1  conversion start pulse, idles low.
- data_out  out  NUM_CH*DATA_WIDTH  channel c in bits [c*DATA_WIDTH +: DATA_WIDTH].
- data_valid  out  1  data_out holds an unconsumed sample set.
- data_ready  in  1  consumer accepts data_out when data_valid && data_ready.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; a sample set completed while the previous set was unconsumed.

Behaviour:
- Reset (async, rst_n=0): state IDLE; S_CLK=0, CONV_ST=0, data_out=0, data_valid=0, busy=0, overrun=0; all counters=0.
- FSM states: IDLE -> CONV -> WAIT -> SHIFT -> DONE -> IDLE.
- IDLE: leave on a start condition (defined below).
- CONV: CONV_ST=1 for exactly CONV_PULSE cycles.
- WAIT: CONV_ST=0 for CONV_WAIT cycles.
- SHIFT: DATA_WIDTH S_CLK periods; each period is CLK_DIV cycles high, then CLK_DIV cycles low.
  - S_DATA is sampled on the fpga_clk edge that drives S_CLK from 1 to 0.
  - Each sampled bit shifts into the per-channel shift register LSB side, so the first bit lands as MSB.
- DONE: one cycle; shift registers load into the output register; return to IDLE.
- Conversion length: CONV_PULSE + CONV_WAIT + 2*CLK_DIV*DATA_WIDTH + 1 cycles (119 with defaults). busy is high for exactly this many cycles.
- Start, single-shot (cont_mode=0): trig=1 while enable=1 and state IDLE. trig outside IDLE is ignored, not queued.
- Start, continuous (cont_mode=1, enable=1):
  - First conversion starts on the cycle after enable is seen high in IDLE.
  - The period counter restarts at each CONV entry; the next start happens when the counter reaches SAMPLE_PERIOD-1.
  - If SAMPLE_PERIOD < conversion length, the next conversion starts the cycle after DONE, with no IDLE gap beyond one cycle.
- enable falling mid-conversion: the conversion completes and its data is delivered; no new conversion starts.
- cont_mode change: takes effect only at the next IDLE decision.
- Output handshake:
  - data_valid rises the cycle after DONE.
  - data_valid clears on the cycle after data_valid && data_ready.
  - data_out is stable while data_valid=1 unless an overrun occurs.
- Overrun: DONE with data_valid=1 and no handshake in that cycle -> data_out is overwritten with the new set, data_valid stays 1, overrun=1.
  - overrun is cleared only by reset or by enable=0.
  - DONE coinciding with a handshake on the old data is not an overrun.
- Arithmetic: all counters are sized via $clog2 of their maximum; no wrap occurs inside a conversion.

Optional Feature:
- Macro: ADC_TEST_PATTERN_EN.
- Defined: adds input port test_mode (1 bit).
  - When test_mode=1 at CONV entry, the DONE load replaces channel c with (sample_count + c) mod 2^DATA_WIDTH.
  - sample_count is an internal DATA_WIDTH counter incremented at each DONE and reset to 0.
  - S_DATA is ignored; S_CLK and CONV_ST timing is unchanged.
- Undefined: no test_mode port, no sample_count; data always comes from S_DATA.

Test Plan:
1. Defaults, cont_mode=0, enable=1, one trig; model drives channel 0 = 0xA5C and channel 1 = 0x3F1, MSB first, 1 ns after each S_CLK rise -> CONV_ST high 2 cycles, exactly 12 S_CLK pulses, busy high 119 cycles, data_valid rises with data_out = {0x3F1, 0xA5C}.
2. cont_mode=1, SAMPLE_PERIOD=1000, data_ready=1 -> CONV_ST rising edges exactly 1000 cycles apart over 5 conversions; overrun stays 0.
3. cont_mode=1, SAMPLE_PERIOD=50 (< 119) -> back-to-back conversions with CONV_ST rises 120 cycles apart.
4. data_ready=0 across two conversions -> overrun=1 after the second DONE, data_out = second set; enable=0 -> overrun clears to 0.
5. Assert rst_n=0 in mid-SHIFT (bit 5) -> S_CLK, CONV_ST, busy and data_valid drop to 0 immediately; after release, a fresh trig captures a correct sample.
6. ADC_TEST_PATTERN_EN defined, test_mode=1, three triggered conversions -> channel 0 = 0, 1, 2 and channel 1 = 1, 2, 3.

Source files
------------

// File: rtl/adc_serial_reader.sv
// Multi-channel serial ADC reader: drives CONV_ST/S_CLK and captures NUM_CH MSB-first lanes.
// Optional macro ADC_TEST_PATTERN_EN adds test_mode, which replaces S_DATA with a counting pattern.
`timescale 1ns/1ps
module adc_serial_reader #(
   parameter int DATA_WIDTH    = 12,
   parameter int NUM_CH        = 2,
   parameter int CLK_DIV       = 4,
   parameter int CONV_PULSE    = 2,
   parameter int CONV_WAIT     = 20,
   parameter int SAMPLE_PERIOD = 1000
) (
   input  logic                         fpga_clk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic                         cont_mode,
   input  logic                         trig,
`ifdef ADC_TEST_PATTERN_EN
   input  logic                         test_mode,
`endif
   input  logic [NUM_CH-1:0]            S_DATA,
   output logic                         S_CLK,
   output logic                         CONV_ST,
   output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
   output logic                         data_valid,
   input  logic                         data_ready,
   output logic                         busy,
   output logic                         overrun
);

   localparam int MAX_A   = (CONV_PULSE > CONV_WAIT) ? CONV_PULSE : CONV_WAIT;
   localparam int CNT_MAX = (MAX_A > 2*CLK_DIV) ? MAX_A : 2*CLK_DIV;
   localparam int CW      = $clog2(CNT_MAX);
   localparam int BW      = $clog2(DATA_WIDTH);
   localparam int PW      = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CONV  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t                               state_r, state_nxt_s;
   logic [CW-1:0]                        cnt_r, cnt_nxt_s;
   logic [BW-1:0]                        bit_r, bit_nxt_s;
   logic [PW-1:0]                        period_r;
   logic                                 armed_r;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0]    sh_r;
   logic [NUM_CH*DATA_WIDTH-1:0]         new_set_s;
   logic [NUM_CH*DATA_WIDTH-1:0]         data_out_r;
   logic                                 data_valid_r, overrun_r;
   logic                                 sclk_r, conv_st_r, busy_r;
   logic                                 sclk_nxt_s, conv_st_nxt_s, busy_nxt_s;
   logic                                 start_s, conv_entry_s, sample_s, done_s, handshake_s;
`ifdef ADC_TEST_PATTERN_EN
   logic                                 tm_r;
   logic [DATA_WIDTH-1:0]                sample_cnt_r;
`endif

   // In continuous mode the first start is immediate; later ones wait for the period counter.
   assign start_s      = enable & (cont_mode ? (~armed_r | (period_r == PW'(SAMPLE_PERIOD - 1))) : trig);
   assign conv_entry_s = (state_r == ST_IDLE) & start_s;
   assign sample_s     = (state_r == ST_SHIFT) & (cnt_r == CW'(CLK_DIV - 1));
   assign done_s       = (state_r == ST_DONE);
   assign handshake_s  = data_valid_r & data_ready;

   // State and sequencing counters
   always_ff @(posedge fpga_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         bit_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         bit_r   <= bit_nxt_s;
      end
   end

   // Next-state and counter advance
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      bit_nxt_s   = bit_r;
      case (state_r)
         ST_IDLE: begin
            cnt_nxt_s = '0;
            bit_nxt_s = '0;
            if (start_s) begin
               state_nxt_s = ST_CONV;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CONV: begin
            if (cnt_r == CW'(CONV_PULSE - 1)) begin
               state_nxt_s = ST_WAIT;
               cnt_nxt_s   = '0;
            end else begin
               cnt_nxt_s = cnt_r + CW'(1);
            end
         end
         ST_WAIT: begin
            if (cnt_r == CW'(CONV_WAIT - 1)) begin
               state_nxt_s = ST_SHIFT;
               cnt_nxt_s   = '0;
               bit_nxt_s   = '0;
            end else begin
               cnt_nxt_s = cnt_r + CW'(1);
            end
         end
         ST_SHIFT: begin
            if (cnt_r == CW'(2*CLK_DIV - 1)) begin
               cnt_nxt_s = '0;
               if (bit_r == BW'(DATA_WIDTH - 1)) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  bit_nxt_s = bit_r + BW'(1);
               end
            end else begin
               cnt_nxt_s = cnt_r + CW'(1);
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
            bit_nxt_s   = '0;
         end
      endcase
   end

   // Pin values for the upcoming state, registered below so they change with state_r
   always_comb begin
      conv_st_nxt_s = (state_nxt_s == ST_CONV);
      sclk_nxt_s    = (state_nxt_s == ST_SHIFT) & (cnt_nxt_s < CW'(CLK_DIV));
      busy_nxt_s    = (state_nxt_s != ST_IDLE);
   end

   // Registered ADC pins and busy
   always_ff @(posedge fpga_clk or negedge rst_n) begin
      if (!rst_n) begin
         conv_st_r <= 1'b0;
         sclk_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         conv_st_r <= conv_st_nxt_s;
         sclk_r    <= sclk_nxt_s;
         busy_r    <= busy_nxt_s;
      end
   end

   // Start-to-start period counter; saturates so a long conversion restarts right after DONE
   always_ff @(posedge fpga_clk or negedge rst_n) begin
      if (!rst_n) begin
         period_r <= '0;
         armed_r  <= 1'b0;
      end else begin
         if (conv_entry_s) begin
            period_r <= '0;
         end else if (period_r != PW'(SAMPLE_PERIOD - 1)) begin
            period_r <= period_r + PW'(1);
         end else begin
            period_r <= period_r;
         end
         if (!enable || !cont_mode) begin
            armed_r <= 1'b0;
         end else if (conv_entry_s) begin
            armed_r <= 1'b1;
         end else begin
            armed_r <= armed_r;
         end
      end
   end

   // Capture on the edge that drops S_CLK; first bit ends up as MSB
   always_ff @(posedge fpga_clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_r <= '0;
      end else if (sample_s) begin
         for (int c = 0; c < NUM_CH; c++) begin
            sh_r[c] <= {sh_r[c][DATA_WIDTH-2:0], S_DATA[c]};
         end
      end else begin
         sh_r <= sh_r;
      end
   end

`ifdef ADC_TEST_PATTERN_EN
   // Test-pattern select latched per conversion, and the running set counter
   always_ff @(posedge fpga_clk or negedge rst_n) begin
      if (!rst_n) begin
         tm_r         <= 1'b0;
         sample_cnt_r <= '0;
      end else begin
         tm_r         <= conv_entry_s ? test_mode : tm_r;
         sample_cnt_r <= done_s ? (sample_cnt_r + DATA_WIDTH'(1)) : sample_cnt_r;
      end
   end
`endif

   // Sample set presented at DONE
   always_comb begin
      new_set_s = '0;
      for (int c = 0; c < NUM_CH; c++) begin
`ifdef ADC_TEST_PATTERN_EN
         new_set_s[c*DATA_WIDTH +: DATA_WIDTH] = tm_r ? (sample_cnt_r + DATA_WIDTH'(c)) : sh_r[c];
`else
         new_set_s[c*DATA_WIDTH +: DATA_WIDTH] = sh_r[c];
`endif
      end
   end

   // Output register, valid flag and sticky overrun (enable low clears overrun)
   always_ff @(posedge fpga_clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_r   <= '0;
         data_valid_r <= 1'b0;
         overrun_r    <= 1'b0;
      end else begin
         if (done_s) begin
            data_out_r   <= new_set_s;
            data_valid_r <= 1'b1;
         end else if (handshake_s) begin
            data_out_r   <= data_out_r;
            data_valid_r <= 1'b0;
         end else begin
            data_out_r   <= data_out_r;
            data_valid_r <= data_valid_r;
         end
         if (!enable) begin
            overrun_r <= 1'b0;
         end else if (done_s && data_valid_r && !data_ready) begin
            overrun_r <= 1'b1;
         end else begin
            overrun_r <= overrun_r;
         end
      end
   end

   assign S_CLK      = sclk_r;
   assign CONV_ST    = conv_st_r;
   assign busy       = busy_r;
   assign data_out   = data_out_r;
   assign data_valid = data_valid_r;
   assign overrun    = overrun_r;

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed bench for adc_serial_reader: default instance plus a short-period continuous instance.
`timescale 1ns/1ps
module tb_adc_serial_reader;

   logic        fpga_clk = 1'b0;
   always #5 fpga_clk = ~fpga_clk;

   logic        rst_n, enable, cont_mode, trig, data_ready;
   logic [1:0]  s_data;
   logic        s_clk_a, conv_st_a, data_valid_a, busy_a, overrun_a;
   logic [23:0] data_out_a;
   logic        enable_b, cont_b, ready_b;
   logic        s_clk_b, conv_st_b, data_valid_b, busy_b, overrun_b;
   logic [23:0] data_out_b;
`ifdef ADC_TEST_PATTERN_EN
   logic        test_mode, test_mode_b;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [11:0] ch0_w, ch1_w;
   int          bit_idx = 0;

   adc_serial_reader dut_a (
      .fpga_clk(fpga_clk), .rst_n(rst_n), .enable(enable), .cont_mode(cont_mode), .trig(trig),
`ifdef ADC_TEST_PATTERN_EN
      .test_mode(test_mode),
`endif
      .S_DATA(s_data), .S_CLK(s_clk_a), .CONV_ST(conv_st_a), .data_out(data_out_a),
      .data_valid(data_valid_a), .data_ready(data_ready), .busy(busy_a), .overrun(overrun_a)
   );

   adc_serial_reader #(.SAMPLE_PERIOD(50)) dut_b (
      .fpga_clk(fpga_clk), .rst_n(rst_n), .enable(enable_b), .cont_mode(cont_b), .trig(1'b0),
`ifdef ADC_TEST_PATTERN_EN
      .test_mode(test_mode_b),
`endif
      .S_DATA(s_data), .S_CLK(s_clk_b), .CONV_ST(conv_st_b), .data_out(data_out_b),
      .data_valid(data_valid_b), .data_ready(ready_b), .busy(busy_b), .overrun(overrun_b)
   );

   // ADC model: new conversion restarts the bit pointer; next bit appears 1 ns after each S_CLK rise
   always @(posedge conv_st_a) bit_idx = 0;
   always @(posedge s_clk_a) begin
      #1;
      if (bit_idx < 12) begin
         s_data  = {ch1_w[11-bit_idx], ch0_w[11-bit_idx]};
         bit_idx = bit_idx + 1;
      end
   end

   task automatic pulse_trig();
      @(negedge fpga_clk); trig = 1'b1;
      @(negedge fpga_clk); trig = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int i;
      i = 0;
      while (busy_a === 1'b1 && i < max_cyc) begin
         @(negedge fpga_clk);
         i++;
      end
      checks++;
      if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_timeout busy=%b want 0", busy_a); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if (s_clk_a !== 1'b0)      begin errors++; $display("FAIL rst_sclk got %b want 0", s_clk_a); end
      checks++; if (conv_st_a !== 1'b0)    begin errors++; $display("FAIL rst_conv got %b want 0", conv_st_a); end
      checks++; if (busy_a !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b want 0", busy_a); end
      checks++; if (data_valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", data_valid_a); end
      checks++; if (overrun_a !== 1'b0)    begin errors++; $display("FAIL rst_overrun got %b want 0", overrun_a); end
      checks++; if (data_out_a !== 24'h0)  begin errors++; $display("FAIL rst_data got %h want 000000", data_out_a); end
      @(negedge fpga_clk); rst_n = 1'b1;
      @(negedge fpga_clk);
   endtask

   task automatic test_single();
      int busy_n, conv_n, sclk_n, valid_at;
      logic prev;
      busy_n = 0; conv_n = 0; sclk_n = 0; valid_at = -1; prev = 1'b0;
      ch0_w = 12'hA5C; ch1_w = 12'h3F1;
      pulse_trig();
      for (int i = 0; i < 300; i++) begin
         if (busy_a) busy_n++;
         if (conv_st_a) conv_n++;
         if (s_clk_a && !prev) sclk_n++;
         prev = s_clk_a;
         if (data_valid_a && valid_at < 0) valid_at = i;
         if (i == 50) trig = 1'b1;
         if (i == 51) trig = 1'b0;
         @(negedge fpga_clk);
      end
      checks++; if (busy_n != 119)  begin errors++; $display("FAIL single_busy_len got %0d want 119", busy_n); end
      checks++; if (conv_n != 2)    begin errors++; $display("FAIL single_conv_len got %0d want 2", conv_n); end
      checks++; if (sclk_n != 12)   begin errors++; $display("FAIL single_sclk_pulses got %0d want 12", sclk_n); end
      checks++; if (valid_at != 119) begin errors++; $display("FAIL single_valid_cycle got %0d want 119", valid_at); end
      checks++; if (data_out_a !== 24'h3F1A5C) begin errors++; $display("FAIL single_data got %h want 3f1a5c", data_out_a); end
      data_ready = 1'b1;
      @(negedge fpga_clk); data_ready = 1'b0;
      checks++; if (data_valid_a !== 1'b0) begin errors++; $display("FAIL single_consume got %b want 0", data_valid_a); end
   endtask

   task automatic test_continuous();
      int rises[5];
      int n;
      logic prev;
      n = 0; prev = conv_st_a;
      data_ready = 1'b1;
      @(negedge fpga_clk); cont_mode = 1'b1;
      for (int i = 0; i < 6000 && n < 5; i++) begin
         @(negedge fpga_clk);
         if (conv_st_a && !prev) begin rises[n] = i; n++; end
         prev = conv_st_a;
      end
      checks++; if (n != 5) begin errors++; $display("FAIL cont_rise_count got %0d want 5", n); end
      if (n == 5) begin
         for (int k = 1; k < 5; k++) begin
            checks++;
            if (rises[k] - rises[k-1] != 1000) begin
               errors++; $display("FAIL cont_spacing%0d got %0d want 1000", k, rises[k] - rises[k-1]);
            end
         end
      end
      checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL cont_overrun got %b want 0", overrun_a); end
      cont_mode = 1'b0;
      wait_idle(300);
      repeat (3) @(negedge fpga_clk);
      data_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int rises[3];
      int n;
      logic prev;
      n = 0; prev = 1'b0;
      @(negedge fpga_clk); enable_b = 1'b1; cont_b = 1'b1;
      for (int i = 0; i < 600 && n < 3; i++) begin
         @(negedge fpga_clk);
         if (conv_st_b && !prev) begin rises[n] = i; n++; end
         prev = conv_st_b;
      end
      checks++; if (n != 3) begin errors++; $display("FAIL b2b_rise_count got %0d want 3", n); end
      if (n == 3) begin
         for (int k = 1; k < 3; k++) begin
            checks++;
            if (rises[k] - rises[k-1] != 120) begin
               errors++; $display("FAIL b2b_spacing%0d got %0d want 120", k, rises[k] - rises[k-1]);
            end
         end
      end
      enable_b = 1'b0;
      for (int i = 0; i < 200 && busy_b === 1'b1; i++) @(negedge fpga_clk);
      checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL b2b_stop busy=%b want 0", busy_b); end
   endtask

   task automatic test_overrun();
      checks++; if (data_valid_a !== 1'b0) begin errors++; $display("FAIL ovr_pre_valid got %b want 0", data_valid_a); end
      ch0_w = 12'h123; ch1_w = 12'h456;
      pulse_trig(); wait_idle(200);
      checks++; if (data_out_a !== 24'h456123) begin errors++; $display("FAIL ovr_first_data got %h want 456123", data_out_a); end
      checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL ovr_first_flag got %b want 0", overrun_a); end
      ch0_w = 12'h789; ch1_w = 12'hABC;
      pulse_trig(); wait_idle(200);
      checks++; if (overrun_a !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun_a); end
      checks++; if (data_valid_a !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", data_valid_a); end
      checks++; if (data_out_a !== 24'hABC789) begin errors++; $display("FAIL ovr_data got %h want abc789", data_out_a); end
      enable = 1'b0;
      @(negedge fpga_clk);
      checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun_a); end
      enable = 1'b1; data_ready = 1'b1;
      @(negedge fpga_clk); data_ready = 1'b0;
      checks++; if (data_valid_a !== 1'b0) begin errors++; $display("FAIL ovr_consume got %b want 0", data_valid_a); end
   endtask

   task automatic test_reset_mid_shift();
      int r;
      logic prev;
      r = 0; prev = 1'b0;
      ch0_w = 12'h0F0; ch1_w = 12'hF0F;
      pulse_trig(); wait_idle(200);
      ch0_w = 12'h555; ch1_w = 12'hAAA;
      pulse_trig();
      for (int i = 0; i < 200 && r < 6; i++) begin
         @(negedge fpga_clk);
         if (s_clk_a && !prev) r++;
         prev = s_clk_a;
      end
      checks++; if (r != 6) begin errors++; $display("FAIL mid_rises got %0d want 6", r); end
      checks++; if ({busy_a, s_clk_a, data_valid_a} !== 3'b111) begin
         errors++; $display("FAIL mid_pre_state got %b want 111", {busy_a, s_clk_a, data_valid_a});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({s_clk_a, conv_st_a, busy_a, data_valid_a} !== 4'b0000) begin
         errors++; $display("FAIL mid_reset_outputs got %b want 0000", {s_clk_a, conv_st_a, busy_a, data_valid_a});
      end
      @(negedge fpga_clk); rst_n = 1'b1;
      @(negedge fpga_clk);
      ch0_w = 12'h5A5; ch1_w = 12'hC3C;
      pulse_trig(); wait_idle(200);
      checks++; if (data_out_a !== 24'hC3C5A5) begin errors++; $display("FAIL mid_recover_data got %h want c3c5a5", data_out_a); end
      checks++; if (data_valid_a !== 1'b1) begin errors++; $display("FAIL mid_recover_valid got %b want 1", data_valid_a); end
      data_ready = 1'b1;
      @(negedge fpga_clk); data_ready = 1'b0;
   endtask

`ifdef ADC_TEST_PATTERN_EN
   task automatic test_pattern();
      logic [23:0] exp_set [3];
      exp_set[0] = 24'h001000; exp_set[1] = 24'h002001; exp_set[2] = 24'h003002;
      @(negedge fpga_clk); rst_n = 1'b0;
      @(negedge fpga_clk); rst_n = 1'b1; test_mode = 1'b1;
      for (int k = 0; k < 3; k++) begin
         pulse_trig(); wait_idle(200);
         checks++;
         if (data_out_a !== exp_set[k]) begin
            errors++; $display("FAIL pattern%0d got %h want %h", k, data_out_a, exp_set[k]);
         end
         data_ready = 1'b1;
         @(negedge fpga_clk); data_ready = 1'b0;
      end
      test_mode = 1'b0;
   endtask
`endif

   initial begin
      rst_n = 1'b0; enable = 1'b1; cont_mode = 1'b0; trig = 1'b0; data_ready = 1'b0;
      s_data = 2'b00; enable_b = 1'b0; cont_b = 1'b0; ready_b = 1'b1;
      ch0_w = 12'h000; ch1_w = 12'h000;
`ifdef ADC_TEST_PATTERN_EN
      test_mode = 1'b0; test_mode_b = 1'b0;
`endif
      test_reset();
      test_single();
      test_continuous();
      test_back_to_back();
      test_overrun();
      test_reset_mid_shift();
`ifdef ADC_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
